// File: rtl/qoi_buffer_ctrl.sv
// Ping-pong ownership controller between the 6502 CPU and the QOI engine for the shared buffer.
// Optional engine watchdog compiled in with `define QOI_BUF_TIMEOUT_EN.
module qoi_buffer_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       flag_i,
    input  logic       start_i,
    input  logic       engine_done_i,
    input  logic       cpu_ack_i,
    output logic       sel_o,
    output logic       engine_start_o,
    output logic       irq_o,
    output logic [1:0] state_o,
    output logic [7:0] block_cnt_o,
    output logic       timeout_o
);

    // state    | meaning
    // FILL     | CPU owns the buffer and writes input data
    // HANDOVER | mux settles toward the engine; engine start pulse
    // RUN      | engine owns the buffer and encodes the block
    // DRAIN    | CPU reads the output block; irq held high
    typedef enum logic [1:0] {
        FILL     = 2'd0,
        HANDOVER = 2'd1,
        RUN      = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       sel_q, start_q, irq_q;
    logic [7:0] cnt_q, cnt_d;
    logic       wd_expired;

`ifdef QOI_BUF_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    assign wd_expired = (wd_q == 16'hFFFF);
    // Held at zero outside RUN, so it is already clear on every entry to RUN.
    assign wd_d       = (state_q == RUN) ? wd_q + 16'd1 : 16'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_expired = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef QOI_BUF_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            FILL: begin
                if (flag_i || start_i) state_d = HANDOVER;
            end
            HANDOVER: begin
                state_d = RUN;
            end
            RUN: begin
                if (engine_done_i) begin
                    state_d = DRAIN;
                    cnt_d   = cnt_q + 8'd1;
                end else if (wd_expired) begin
                    state_d = DRAIN;
`ifdef QOI_BUF_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            DRAIN: begin
                if (cpu_ack_i) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Outputs are registered from the next-state decode so they change on the same edge as state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= 8'd0;
            sel_q   <= 1'b0;
            start_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= (state_d == HANDOVER) || (state_d == RUN);
            start_q <= (state_d == HANDOVER);
            irq_q   <= (state_d == DRAIN);
        end
    end

    assign sel_o          = sel_q;
    assign engine_start_o = start_q;
    assign irq_o          = irq_q;
    assign state_o        = state_q;
    assign block_cnt_o    = cnt_q;

endmodule

// File: tb/tb_qoi_buffer_ctrl.sv
// Self-checking bench for qoi_buffer_ctrl: behavioural model compared every cycle plus directed literals.
module tb_qoi_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flag_i = 1'b0, start_i = 1'b0, engine_done_i = 1'b0, cpu_ack_i = 1'b0;
    logic       sel_o, engine_start_o, irq_o, timeout_o;
    logic [1:0] state_o;
    logic [7:0] block_cnt_o;

    int n_pass = 0;
    int n_total = 0;

    qoi_buffer_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .flag_i         (flag_i),
        .start_i        (start_i),
        .engine_done_i  (engine_done_i),
        .cpu_ack_i      (cpu_ack_i),
        .sel_o          (sel_o),
        .engine_start_o (engine_start_o),
        .irq_o          (irq_o),
        .state_o        (state_o),
        .block_cnt_o    (block_cnt_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    // Reference: phase of the buffer hand-off (0 CPU fills, 1 handover, 2 engine runs, 3 CPU drains).
    int m_phase;
    int m_blocks;
    bit m_timeout;
    int m_run_edges;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_blocks = 0;
            m_timeout = 0;
            m_run_edges = 0;
        end else begin
            if (m_phase == 0) begin
                if (flag_i || start_i) m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_run_edges = 0;
            end else if (m_phase == 2) begin
                if (engine_done_i) begin
                    m_phase = 3;
                    m_blocks = (m_blocks + 1) % 256;
                end
`ifdef QOI_BUF_TIMEOUT_EN
                else if (m_run_edges == 65535) begin
                    m_phase = 3;
                    m_timeout = 1;
                end
`endif
                else m_run_edges++;
            end else begin
                if (cpu_ack_i) m_phase = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("model state", int'(state_o), m_phase);
            check("model sel", int'(sel_o), int'(m_phase == 1 || m_phase == 2));
            check("model start", int'(engine_start_o), int'(m_phase == 1));
            check("model irq", int'(irq_o), int'(m_phase == 3));
            check("model cnt", int'(block_cnt_o), m_blocks);
            check("model timeout", int'(timeout_o), int'(m_timeout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic one_block();
        flag_i = 1'b1; tick(); flag_i = 1'b0;
        tick();
        engine_done_i = 1'b1; tick(); engine_done_i = 1'b0;
        cpu_ack_i = 1'b1; tick(); cpu_ack_i = 1'b0;
    endtask

    initial begin
        #12;
        check("reset state", int'(state_o), 0);
        check("reset sel", int'(sel_o), 0);
        check("reset cnt", int'(block_cnt_o), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle fill", int'(state_o), 0);

        flag_i = 1'b1; tick(); flag_i = 1'b0;
        check("flag->handover", int'(state_o), 1);
        check("handover start", int'(engine_start_o), 1);
        check("handover sel", int'(sel_o), 1);
        tick();
        check("run state", int'(state_o), 2);
        check("start one cycle", int'(engine_start_o), 0);
        cpu_ack_i = 1'b1; tick(); cpu_ack_i = 1'b0;
        check("ack in run ignored", int'(state_o), 2);
        engine_done_i = 1'b1; tick(); engine_done_i = 1'b0;
        check("drain state", int'(state_o), 3);
        check("drain irq", int'(irq_o), 1);
        check("drain sel", int'(sel_o), 0);
        check("drain cnt", int'(block_cnt_o), 1);
        flag_i = 1'b1; engine_done_i = 1'b1; tick(); flag_i = 1'b0; engine_done_i = 1'b0;
        check("flag in drain ignored", int'(state_o), 3);
        cpu_ack_i = 1'b1; tick(); cpu_ack_i = 1'b0;
        check("ack->fill", int'(state_o), 0);
        check("ack irq low", int'(irq_o), 0);

        engine_done_i = 1'b1; tick(); engine_done_i = 1'b0;
        check("done in fill ignored", int'(state_o), 0);
        check("done in fill cnt", int'(block_cnt_o), 1);
        flag_i = 1'b1; start_i = 1'b1; tick(); flag_i = 1'b0; start_i = 1'b0;
        check("both -> handover", int'(state_o), 1);
        tick();
        check("both single start", int'(engine_start_o), 0);

        // Engine never finishes: watchdog behaviour depends on the build.
`ifdef QOI_BUF_TIMEOUT_EN
        repeat (65535) tick();
        check("wd still run", int'(state_o), 2);
        tick();
        check("wd drain", int'(state_o), 3);
        check("wd timeout", int'(timeout_o), 1);
        check("wd cnt unchanged", int'(block_cnt_o), 1);
        cpu_ack_i = 1'b1; tick(); cpu_ack_i = 1'b0;
        one_block();
        check("timeout sticky", int'(timeout_o), 1);
`else
        repeat (300) tick();
        check("no wd run", int'(state_o), 2);
        check("no wd timeout", int'(timeout_o), 0);
`endif

        // Async reset between edges while the engine owns the buffer.
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async rst state", int'(state_o), 0);
        check("async rst sel", int'(sel_o), 0);
        check("async rst irq", int'(irq_o), 0);
        check("async rst start", int'(engine_start_o), 0);
        check("async rst timeout", int'(timeout_o), 0);
        @(negedge clk);
        rst = 1'b0;
        flag_i = 1'b1; tick(); flag_i = 1'b0;
        check("first edge after rst", int'(state_o), 1);
        tick();
        engine_done_i = 1'b1; tick(); engine_done_i = 1'b0;
        cpu_ack_i = 1'b1; tick(); cpu_ack_i = 1'b0;
        check("cnt after rst block", int'(block_cnt_o), 1);

        for (int i = 0; i < 254; i++) one_block();
        check("cnt 255", int'(block_cnt_o), 255);
        one_block();
        check("cnt wraps 0", int'(block_cnt_o), 0);
        one_block();
        check("cnt after wrap", int'(block_cnt_o), 1);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
